// File: rtl/inpkt_word_parser.sv
// Receive-side header parser for the 16-bit host input stream.
// Consumes a five-word little-endian header (version/type, checksum,
// 32-bit length, packet id), validates it and forwards the payload words
// downstream with zero latency, tagged with type, id and first/last flags.
// A bad header parks the block in a terminal error state until reset.

module inpkt_word_parser #(
    parameter logic [7:0] VERSION = 8'h01,
    parameter int         MAX_LEN = 16384
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        empty,
    output logic        rd_en,
    output logic [15:0] dout,
    output logic        wr_en,
    input  logic        full,
    output logic [7:0]  pkt_type,
    output logic [15:0] pkt_id,
    output logic        pkt_new,
    output logic        pkt_end,
    output logic        err_version,
    output logic        err_type,
    output logic        err_len
);

    // Word counter must hold MAX_LEN/2 itself, not just MAX_LEN/2-1.
    localparam int             CW         = $clog2(MAX_LEN / 2 + 1);
    localparam logic [31:0]    MAX_LEN_32 = 32'(MAX_LEN);
    localparam logic [CW-1:0]  ONE_CNT    = CW'(1);

    typedef enum logic [2:0] {
        S_H0   = 3'd0,
        S_H1   = 3'd1,
        S_H2   = 3'd2,
        S_H3   = 3'd3,
        S_H4   = 3'd4,
        S_DATA = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t         state_r;
    logic [15:0]    len_lo_r;
    logic [CW-1:0]  remaining_r;
    logic           first_r;
    logic [7:0]     pkt_type_r;
    logic [15:0]    pkt_id_r;
    logic           err_version_r;
    logic           err_type_r;
    logic           err_len_r;

    logic [31:0]    len32_s;
    logic           len_bad_s;
    logic           ver_bad_s;
    logic           type_bad_s;
    logic           last_word_s;
    logic           rd_en_s;
    logic           wr_en_s;

    assign pkt_type    = pkt_type_r;
    assign pkt_id      = pkt_id_r;
    assign err_version = err_version_r;
    assign err_type    = err_type_r;
    assign err_len     = err_len_r;
    assign rd_en       = rd_en_s;
    assign wr_en       = wr_en_s;

    // Header field checks; the full 32-bit length is judged before truncation.
    always_comb begin
        len32_s     = {din, len_lo_r};
        len_bad_s   = (len32_s == 32'd0) | len32_s[0] | (len32_s > MAX_LEN_32);
        ver_bad_s   = (din[7:0] != VERSION);
        type_bad_s  = (din[15:8] == 8'h00);
        last_word_s = (remaining_r == ONE_CNT);
    end

    // FIFO read strobe: headers ignore downstream backpressure, payload honours it.
    // Gated by rst_n so nothing is read while reset is held.
    always_comb begin
        rd_en_s = 1'b0;
        case (state_r)
            S_H0, S_H1, S_H2, S_H3, S_H4: rd_en_s = rst_n & ~empty;
            S_DATA:                       rd_en_s = rst_n & ~empty & ~full;
            S_ERR:                        rd_en_s = 1'b0;
            default:                      rd_en_s = 1'b0;
        endcase
    end

    // Payload pass-through: each word read in DATA is written out the same cycle.
    always_comb begin
        wr_en_s = 1'b0;
        dout    = 16'h0000;
        pkt_new = 1'b0;
        pkt_end = 1'b0;
        if (state_r == S_DATA) begin
            wr_en_s = rd_en_s;
            dout    = rd_en_s ? din : 16'h0000;
            pkt_new = rd_en_s & first_r;
            pkt_end = rd_en_s & last_word_s;
        end else begin
            wr_en_s = 1'b0;
            dout    = 16'h0000;
        end
    end

    // Header/payload sequencer; advances only on a consumed word.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_H0;
            len_lo_r      <= 16'h0000;
            remaining_r   <= '0;
            first_r       <= 1'b0;
            pkt_type_r    <= 8'h00;
            pkt_id_r      <= 16'h0000;
            err_version_r <= 1'b0;
            err_type_r    <= 1'b0;
            err_len_r     <= 1'b0;
        end else if (rd_en_s) begin
            case (state_r)
                S_H0: begin
                    pkt_type_r <= din[15:8];
                    if (ver_bad_s || type_bad_s) begin
                        err_version_r <= err_version_r | ver_bad_s;
                        err_type_r    <= err_type_r | type_bad_s;
                        state_r       <= S_ERR;
                    end else begin
                        state_r <= S_H1;
                    end
                end
                S_H1: state_r <= S_H2;
                S_H2: begin
                    len_lo_r <= din;
                    state_r  <= S_H3;
                end
                S_H3: begin
                    if (len_bad_s) begin
                        err_len_r <= 1'b1;
                        state_r   <= S_ERR;
                    end else begin
                        remaining_r <= len32_s[CW:1];
                        state_r     <= S_H4;
                    end
                end
                S_H4: begin
                    pkt_id_r <= din;
                    first_r  <= 1'b1;
                    state_r  <= S_DATA;
                end
                S_DATA: begin
                    first_r <= 1'b0;
                    if (last_word_s) begin
                        state_r <= S_H0;
                    end else begin
                        remaining_r <= remaining_r - ONE_CNT;
                    end
                end
                S_ERR:   state_r <= S_ERR;
                default: state_r <= S_H0;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: doc/inpkt_word_parser.md
Name: inpkt_word_parser

Overview:
- Receive-side counterpart of the 0x81 output packetizer.
- Reads a 16-bit packet stream from the host input FIFO (FWFT style) and parses the 10-byte header: version, type, checksum, length, packet id.
- Validates the header, then passes payload words downstream, tagged with packet type, packet id and first/last flags.
- Sits between the input FIFO and the command/word-list consumers.

Parameters:
VERSION, 8'h01, required protocol version byte
MAX_LEN, 16384, maximum accepted payload length in bytes; even, at least 2

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
din  in  16  input FIFO data (FWFT: valid while ~empty)
empty  in  1  input FIFO empty
rd_en  out  1  input FIFO read strobe
dout  out  16  payload word (equals din while wr_en)
wr_en  out  1  payload word valid/write strobe
full  in  1  downstream full; blocks wr_en
pkt_type  out  8  type byte of current packet
pkt_id  out  16  id of current packet
pkt_new  out  1  with wr_en: first payload word of packet
pkt_end  out  1  with wr_en: last payload word of packet
err_version  out  1  sticky: version mismatch
err_type  out  1  sticky: type byte 0
err_len  out  1  sticky: length zero, odd or > MAX_LEN

Behaviour:
- Reset (async, rst_n=0):
  - state=H0; counters 0.
  - pkt_type=0, pkt_id=0, all err_* = 0.
  - rd_en=wr_en=pkt_new=pkt_end=0.
  - Reset mid-packet discards the partial packet; the next word after release is parsed as header word 0.
- Header words, little-endian byte order, one word consumed per cycle when ~empty:
  - H0 {type[15:8], version[7:0]}: load pkt_type. Version!=VERSION -> ERR with err_version; type==0 -> ERR with err_type; both may set together.
  - H1 checksum: read and ignored.
  - H2 length[15:0]: latch.
  - H3 length[31:16]: evaluate full 32-bit length. 0, bit0=1, or >MAX_LEN -> ERR with err_len. Otherwise remaining=length/2 and go to H4.
  - H4 pkt_id: load pkt_id; go to DATA; set first flag.
- rd_en (combinational):
  - H0..H4: rd_en = ~empty.
  - DATA: rd_en = ~empty & ~full.
  - ERR: rd_en = 0.
- DATA:
  - wr_en = rd_en; dout = din; zero latency, no extra buffering.
  - pkt_new = wr_en & first. first clears on that write.
  - pkt_end = wr_en & (remaining==1). On that write, go to H0.
  - Otherwise remaining decrements on each write.
  - A one-word packet (length 2) asserts pkt_new and pkt_end on the same cycle.
- Stalls:
  - empty stalls any state with no state change.
  - full stalls DATA only; header parsing proceeds while full.
- pkt_type/pkt_id:
  - Hold stable from header capture through the last payload word.
  - Updated only when the next packet's H0 or H4 word is read.
- Back-to-back packets: the next packet's H0 is read the cycle after pkt_end; no idle cycle inserted.
- ERR:
  - Terminal; stops reading and writing.
  - err_* hold until reset.
  - Nothing from a failed header reaches dout.
- Counter width: enough for MAX_LEN/2. The 32-bit length is compared before truncation.

Test Plan:
1. Packet words 0x0101,0x0000,0x000E,0x0000,0x1234 then payload 0xA001..0xA007, full=0, no empty gaps -> 7 wr_en cycles with dout A001..A007, pkt_new on A001 only, pkt_end on A007 only, pkt_type=0x01, pkt_id=0x1234. H0 through the last payload word takes exactly 12 cycles.
2. Two back-to-back packets (ids 0x0001, 0x0002, length 4), then the same stream with random empty gaps -> identical output word sequence; pkt_id switches only after the first packet's pkt_end.
3. Packet length 14 with full asserted for 5 cycles mid-payload -> rd_en=wr_en=0 while full; no word lost or duplicated; pkt_end still on the 7th word.
4. H0=0x0102 (version 2) -> err_version=1 after one read; rd_en stays 0 thereafter with empty=0; wr_en never asserted. Repeat with H0=0x0001 -> err_type.
5. Length fields 13; 0; 0x00010000 (high word 1); MAX_LEN+2 -> err_len each case after the H3 read; pkt_id unchanged.
6. Assert rst_n=0 for one cycle after the 3rd payload word of a length-14 packet, then feed a fresh valid packet -> all outputs 0 during reset; new packet parsed correctly with pkt_new on its first word.
